// File: rtl/kgp_control_unit.sv
// Multi-cycle control FSM for the KGP core: sequences fetch, decode, execute,
// data-memory access, write-back and branch, with a bounded memory wait.
module kgp_control_unit #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] opCode,
   input  logic [3:0] functCode,
   input  logic       zero,
   input  logic       carry,
   input  logic       sign,
   input  logic       mem_ack,
   output logic       ir_we,
   output logic       pc_we,
   output logic       reg_we,
   output logic       flags_we,
   output logic       alu_src,
   output logic [1:0] pc_src,
   output logic [3:0] alu_op,
   output logic       wb_src,
   output logic       mem_req,
   output logic       mem_we,
   output logic [2:0] state,
   output logic       halted,
   output logic       err
);
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      BRANCH = 3'd5,
      HALT   = 3'd6,
      ERROR  = 3'd7
   } state_t;

   localparam logic [2:0] OP_ALU  = 3'b000;
   localparam logic [2:0] OP_ALUI = 3'b001;
   localparam logic [2:0] OP_MEM  = 3'b010;
   localparam logic [2:0] OP_BR   = 3'b011;
   localparam logic [2:0] OP_JR   = 3'b100;
   localparam logic [2:0] OP_HALT = 3'b111;

   localparam int                WAIT_W    = $clog2(MEM_WAIT_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

   state_t            cur, nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              is_store, br_valid, br_taken;

   assign is_store = (functCode == 4'b0001);
   assign state    = cur;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      br_valid = 1'b1;
      br_taken = 1'b0;
      case (functCode)
         4'b0000: br_taken = 1'b1;
         4'b0001: br_taken = zero;
         4'b0010: br_taken = ~zero;
         4'b0011: br_taken = carry;
         4'b0100: br_taken = sign;
         default: br_valid = 1'b0;
      endcase
   end

   always_comb begin
      nxt = cur;
      case (cur)
         FETCH:  nxt = DECODE;
         DECODE: begin
            case (opCode)
               OP_ALU, OP_ALUI: nxt = EXEC;
               OP_MEM:          nxt = (functCode[3:1] == 3'b000) ? EXEC : ERROR;
               OP_BR, OP_JR:    nxt = BRANCH;
               OP_HALT:         nxt = HALT;
               default:         nxt = ERROR;
            endcase
         end
         EXEC:   nxt = (opCode == OP_MEM) ? MEM : WB;
         // An acknowledge in the final allowed wait cycle still completes the access.
         MEM: begin
            if (mem_ack)                    nxt = is_store ? FETCH : WB;
            else if (wait_cnt == WAIT_LAST) nxt = ERROR;
         end
         WB:     nxt = FETCH;
         BRANCH: nxt = (opCode == OP_BR && !br_valid) ? ERROR : FETCH;
         default: nxt = cur;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur      <= FETCH;
         wait_cnt <= '0;
      end else begin
         cur <= nxt;
         if (cur != MEM)    wait_cnt <= '0;
         else if (!mem_ack) wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   // Outputs decode the current state so the branch decision sees the flags of
   // the BRANCH cycle itself; rst_n gates them because reset parks us in FETCH.
   always_comb begin
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      reg_we   = 1'b0;
      flags_we = 1'b0;
      alu_src  = 1'b0;
      pc_src   = 2'd0;
      alu_op   = 4'd0;
      wb_src   = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      halted   = 1'b0;
      err      = 1'b0;
      if (rst_n) begin
         case (cur)
            FETCH: begin
               ir_we = 1'b1;
               pc_we = 1'b1;
            end
            EXEC: begin
               alu_op   = (opCode == OP_MEM) ? 4'd0 : functCode;
               alu_src  = (opCode != OP_ALU);
               flags_we = (opCode != OP_MEM);
            end
            MEM: begin
               mem_req = 1'b1;
               mem_we  = is_store;
            end
            WB: begin
               reg_we = 1'b1;
               wb_src = (opCode == OP_MEM);
            end
            BRANCH: begin
               if (opCode == OP_JR) begin
                  pc_we  = 1'b1;
                  pc_src = 2'd2;
               end else if (opCode == OP_BR && br_valid && br_taken) begin
                  pc_we  = 1'b1;
                  pc_src = 2'd1;
               end
            end
            HALT:    halted = 1'b1;
            ERROR:   err    = 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_kgp_control_unit.sv
// Randomized bench for kgp_control_unit: a per-instruction reference model builds
// the expected cycle-by-cycle trace, which is compared at each falling edge.
module tb_kgp_control_unit;
   localparam int MAX = 15;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_BRANCH = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;
   localparam logic [2:0] S_ERROR  = 3'd7;

   typedef struct packed {
      logic [2:0] st;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       reg_we;
      logic       flags_we;
      logic       alu_src;
      logic [3:0] alu_op;
      logic       wb_src;
      logic       mem_req;
      logic       mem_we;
      logic       halted;
      logic       err;
   } sig_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] opCode;
   logic [3:0] functCode;
   logic       zero, carry, sign, mem_ack;
   logic       ir_we, pc_we, reg_we, flags_we, alu_src, wb_src, mem_req, mem_we;
   logic [1:0] pc_src;
   logic [3:0] alu_op;
   logic [2:0] state;
   logic       halted, err;
   sig_t       obs;

   int   total  = 0;
   int   passed = 0;
   sig_t exp_q[$];

   always #5 clk = ~clk;

   kgp_control_unit #(.MEM_WAIT_MAX(MAX)) dut (
      .clk(clk), .rst_n(rst_n), .opCode(opCode), .functCode(functCode),
      .zero(zero), .carry(carry), .sign(sign), .mem_ack(mem_ack),
      .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .flags_we(flags_we),
      .alu_src(alu_src), .pc_src(pc_src), .alu_op(alu_op), .wb_src(wb_src),
      .mem_req(mem_req), .mem_we(mem_we), .state(state), .halted(halted), .err(err)
   );

   assign obs = {state, ir_we, pc_we, pc_src, reg_we, flags_we, alu_src, alu_op,
                 wb_src, mem_req, mem_we, halted, err};

   function automatic sig_t blank(input logic [2:0] st);
      sig_t r;
      r        = '0;
      r.st     = st;
      r.halted = (st == S_HALT);
      r.err    = (st == S_ERROR);
      return r;
   endfunction

   // Reference model: expected cycles of one instruction, from FETCH up to the
   // next FETCH (exclusive) or into a terminal state. fl = {zero, carry, sign}.
   function automatic void build(input logic [2:0] op, input logic [3:0] fn,
                                 input logic [2:0] fl, input int ack_at);
      sig_t r;
      int   waits;
      logic taken, valid;
      r = blank(S_FETCH); r.ir_we = 1'b1; r.pc_we = 1'b1; exp_q.push_back(r);
      exp_q.push_back(blank(S_DECODE));
      case (op)
         3'd0, 3'd1: begin
            r = blank(S_EXEC); r.alu_op = fn; r.alu_src = (op == 3'd1); r.flags_we = 1'b1;
            exp_q.push_back(r);
            r = blank(S_WB); r.reg_we = 1'b1; exp_q.push_back(r);
         end
         3'd2: begin
            if (fn > 4'd1) exp_q.push_back(blank(S_ERROR));
            else begin
               r = blank(S_EXEC); r.alu_src = 1'b1; exp_q.push_back(r);
               waits = (ack_at < 1 || ack_at > MAX) ? MAX : ack_at;
               for (int k = 0; k < waits; k++) begin
                  r = blank(S_MEM); r.mem_req = 1'b1; r.mem_we = (fn == 4'd1);
                  exp_q.push_back(r);
               end
               if (ack_at < 1 || ack_at > MAX) exp_q.push_back(blank(S_ERROR));
               else if (fn == 4'd0) begin
                  r = blank(S_WB); r.reg_we = 1'b1; r.wb_src = 1'b1; exp_q.push_back(r);
               end
            end
         end
         3'd3: begin
            valid = (fn <= 4'd4);
            case (fn)
               4'd0:    taken = 1'b1;
               4'd1:    taken = fl[2];
               4'd2:    taken = !fl[2];
               4'd3:    taken = fl[1];
               4'd4:    taken = fl[0];
               default: taken = 1'b0;
            endcase
            r = blank(S_BRANCH);
            if (valid && taken) begin r.pc_we = 1'b1; r.pc_src = 2'd1; end
            exp_q.push_back(r);
            if (!valid) exp_q.push_back(blank(S_ERROR));
         end
         3'd4: begin
            r = blank(S_BRANCH); r.pc_we = 1'b1; r.pc_src = 2'd2; exp_q.push_back(r);
         end
         3'd7:    exp_q.push_back(blank(S_HALT));
         default: exp_q.push_back(blank(S_ERROR));
      endcase
   endfunction

   // Drives one instruction cycle by cycle; must be entered during a FETCH cycle,
   // before its falling edge. extra repeats the last record, limit truncates.
   task automatic run_trace(input string name, input logic [2:0] op, input logic [3:0] fn,
                            input logic [2:0] fl, input int ack_at, input int extra,
                            input int limit);
      int   mem_n = 0;
      int   n;
      sig_t last;
      build(op, fn, fl, ack_at);
      last = exp_q[exp_q.size()-1];
      for (int k = 0; k < extra; k++) exp_q.push_back(last);
      n = (limit > 0 && limit < exp_q.size()) ? limit : exp_q.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (exp_q[i].st == S_FETCH) begin
            opCode    = 3'($urandom);
            functCode = 4'($urandom);
         end else begin
            opCode    = op;
            functCode = fn;
         end
         {zero, carry, sign} = (exp_q[i].st == S_BRANCH) ? fl : 3'($urandom);
         if (exp_q[i].st == S_MEM) begin
            mem_n++;
            mem_ack = (mem_n == ack_at);
         end else mem_ack = 1'($urandom);
         #1;
         total++;
         if (obs !== exp_q[i])
            $display("FAIL %s cycle %0d: got state=%0d bits=%h, want state=%0d bits=%h",
                     name, i, obs.st, obs, exp_q[i].st, exp_q[i]);
         else passed++;
      end
      exp_q.delete();
   endtask

   task automatic apply_reset();
      rst_n   = 1'b0;
      mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; opCode = 3'd0; functCode = 4'd0;
      zero = 1'b0; carry = 1'b0; sign = 1'b0; mem_ack = 1'b0;
      repeat (3) begin
         @(negedge clk);
         {zero, carry, sign, mem_ack} = 4'($urandom);
         opCode = 3'($urandom);
         #1;
         total++;
         if (obs !== blank(S_FETCH)) $display("FAIL reset_hold: got %h want %h", obs, blank(S_FETCH));
         else passed++;
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_alu();
      run_trace("alu_0011", 3'd0, 4'b0011, 3'($urandom), 0, 0, 0);
      run_trace("alu_rr",   3'd0, 4'($urandom), 3'($urandom), 0, 0, 0);
      run_trace("alu_imm",  3'd1, 4'($urandom), 3'($urandom), 0, 0, 0);
   endtask

   task automatic test_mem();
      run_trace("load_ack3",   3'd2, 4'd0, 3'($urandom), 3, 0, 0);
      run_trace("store_ack1",  3'd2, 4'd1, 3'($urandom), 1, 0, 0);
      run_trace("load_ack_max", 3'd2, 4'd0, 3'($urandom), MAX, 0, 0);
      run_trace("store_timeout", 3'd2, 4'd1, 3'($urandom), 0, 5, 0);
      apply_reset();
   endtask

   task automatic test_branch();
      run_trace("beqz_taken", 3'd3, 4'd1, 3'b100, 0, 0, 0);
      run_trace("beqz_not",   3'd3, 4'd1, 3'b011, 0, 0, 0);
      run_trace("bnez_taken", 3'd3, 4'd2, 3'b000, 0, 0, 0);
      run_trace("bc_not",     3'd3, 4'd3, 3'b101, 0, 0, 0);
      run_trace("bs_taken",   3'd3, 4'd4, 3'b001, 0, 0, 0);
      run_trace("jr",         3'd4, 4'($urandom), 3'($urandom), 0, 0, 0);
      run_trace("br_bad_fn",  3'd3, 4'b0110, 3'($urandom), 0, 2, 0);
      apply_reset();
   endtask

   task automatic test_halt();
      run_trace("halt", 3'd7, 4'($urandom), 3'($urandom), 0, 20, 0);
      rst_n = 1'b0;
      #1;
      total++;
      if (obs !== blank(S_FETCH)) $display("FAIL halt_async_reset: got %h want %h", obs, blank(S_FETCH));
      else passed++;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_illegal();
      run_trace("op101", 3'd5, 4'($urandom), 3'($urandom), 0, 3, 0);
      apply_reset();
      run_trace("op110", 3'd6, 4'($urandom), 3'($urandom), 0, 3, 0);
      apply_reset();
      run_trace("mem_bad_fn", 3'd2, 4'b0111, 3'($urandom), 0, 2, 0);
      apply_reset();
   endtask

   task automatic test_async_mem_reset();
      run_trace("load_pre_reset", 3'd2, 4'd0, 3'($urandom), 0, 0, 5);
      rst_n = 1'b0;
      #1;
      total++;
      if (obs !== blank(S_FETCH)) $display("FAIL mem_async_reset: got %h want %h", obs, blank(S_FETCH));
      else passed++;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [2:0] op;
      logic [3:0] fn;
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 4))
            0:       begin op = 3'd0; fn = 4'($urandom); end
            1:       begin op = 3'd1; fn = 4'($urandom); end
            2:       begin op = 3'd2; fn = 4'($urandom_range(0, 1)); end
            3:       begin op = 3'd3; fn = 4'($urandom_range(0, 4)); end
            default: begin op = 3'd4; fn = 4'($urandom); end
         endcase
         run_trace("random", op, fn, 3'($urandom), int'($urandom_range(1, 6)), 0, 0);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mem();
      test_branch();
      test_halt();
      test_illegal();
      test_async_mem_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
